fir_interp2: RTL and testbench

// - 2x interpolating polyphase FIR on the transmit path; dual of the 8-tap symmetric receive FIR.
// - One 12-bit sample in, two 27-bit samples out (even phase, then odd phase).
// - Prototype taps h0..h7 = 41,132,341,510,510,341,132,41. Per-phase DC gain = 1024.
// - One time-shared multiplier; MAC runs 4 cycles per phase; valid/ready on both sides.

---
 rtl/fir_interp2_pkg.sv | 28 ++
 rtl/fir_mac_unit.sv | 31 +++
 rtl/fir_interp2.sv | 128 ++++++++++++
 tb/tb_fir_interp2.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/fir_interp2_pkg.sv
// Shared constants for the 2x interpolating polyphase FIR: widths, FSM states, prototype taps.
package fir_interp2_pkg;
  localparam int D_IDATA_WIDTH    = 12;
  localparam int D_COEFF_WIDTH    = 12;
  localparam int D_ACC_WIDTH      = 27;
  localparam int D_OUT_WIDTH      = 27;
  localparam int D_NUM_PHASE_TAPS = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MAC_E = 3'd1,
    OUT_E = 3'd2,
    MAC_O = 3'd3,
    OUT_O = 3'd4
  } state_t;

  localparam logic signed [D_COEFF_WIDTH-1:0] H0 = 12'sd41;
  localparam logic signed [D_COEFF_WIDTH-1:0] H1 = 12'sd132;
  localparam logic signed [D_COEFF_WIDTH-1:0] H2 = 12'sd341;
  localparam logic signed [D_COEFF_WIDTH-1:0] H3 = 12'sd510;
  localparam logic signed [D_COEFF_WIDTH-1:0] H4 = 12'sd510;
  localparam logic signed [D_COEFF_WIDTH-1:0] H5 = 12'sd341;
  localparam logic signed [D_COEFF_WIDTH-1:0] H6 = 12'sd132;
  localparam logic signed [D_COEFF_WIDTH-1:0] H7 = 12'sd41;

  // Indexed by {tap, odd}: even phase uses h[2*tap], odd phase h[2*tap+1].
  localparam logic signed [D_COEFF_WIDTH-1:0] H [8] = '{H0, H1, H2, H3, H4, H5, H6, H7};
endpackage

// File: rtl/fir_mac_unit.sv
// Time-shared signed multiply-accumulate; acc presents the running sum including the current product.
module fir_mac_unit #(
  parameter int COEFF_WIDTH = 12,
  parameter int DATA_WIDTH  = 12,
  parameter int ACC_WIDTH   = 27
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clr,
  input  logic                          en,
  input  logic signed [COEFF_WIDTH-1:0] coeff,
  input  logic signed [DATA_WIDTH-1:0]  sample,
  output logic signed [ACC_WIDTH-1:0]   acc
);
  localparam int PW = COEFF_WIDTH + DATA_WIDTH;

  logic signed [PW-1:0]        prod;
  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic signed [ACC_WIDTH-1:0] acc_q;

  assign prod     = coeff * sample;
  assign prod_ext = {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};
  // Combinational so the last tap's product lands in the output register without an extra cycle.
  assign acc      = acc_q + prod_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   acc_q <= '0;
    else if (clr) acc_q <= '0;
    else if (en)  acc_q <= acc;
  end
endmodule

// File: rtl/fir_interp2.sv
// 2x interpolating polyphase FIR: one input sample yields an even-phase then an odd-phase output.
module fir_interp2
  import fir_interp2_pkg::*;
#(
  parameter int IDATA_WIDTH    = D_IDATA_WIDTH,
  parameter int COEFF_WIDTH    = D_COEFF_WIDTH,
  parameter int ACC_WIDTH      = D_ACC_WIDTH,
  parameter int OUT_WIDTH      = D_OUT_WIDTH,
  parameter int NUM_PHASE_TAPS = D_NUM_PHASE_TAPS
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic signed [IDATA_WIDTH-1:0] in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic signed [OUT_WIDTH-1:0]   out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_phase
);
  localparam int TAP_W = $clog2(NUM_PHASE_TAPS);
  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(NUM_PHASE_TAPS - 1);

  state_t state, nxt;
  logic [TAP_W-1:0] tap;
  logic [NUM_PHASE_TAPS-1:0][IDATA_WIDTH-1:0] x;
  logic mac_clr, mac_en, odd, load_out, shift_in;
  logic signed [COEFF_WIDTH-1:0] coeff;
  logic signed [IDATA_WIDTH-1:0] sample;
  logic signed [ACC_WIDTH-1:0]   sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt      = state;
    in_ready = 1'b0;
    shift_in = 1'b0;
    mac_clr  = 1'b0;
    mac_en   = 1'b0;
    odd      = 1'b0;
    load_out = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          shift_in = 1'b1;
          mac_clr  = 1'b1;
          nxt      = MAC_E;
        end
      end
      MAC_E: begin
        mac_en = 1'b1;
        if (tap == LAST_TAP) begin
          load_out = 1'b1;
          nxt      = OUT_E;
        end
      end
      OUT_E: begin
        if (out_valid && out_ready) begin
          mac_clr = 1'b1;
          nxt     = MAC_O;
        end
      end
      MAC_O: begin
        mac_en = 1'b1;
        odd    = 1'b1;
        if (tap == LAST_TAP) begin
          load_out = 1'b1;
          nxt      = OUT_O;
        end
      end
      OUT_O: begin
        odd = 1'b1;
        if (out_valid && out_ready) begin
          mac_clr = 1'b1;
          nxt     = IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       tap <= '0;
    else if (mac_clr) tap <= '0;
    else if (mac_en)  tap <= tap + 1'b1;
  end

  // Delay line moves only on an input handshake; x[0] is the newest sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        x <= '0;
    else if (shift_in) x <= {x[NUM_PHASE_TAPS-2:0], in_data};
  end

  assign coeff  = H[{tap, odd}];
  assign sample = x[tap];

  fir_mac_unit #(
    .COEFF_WIDTH(COEFF_WIDTH),
    .DATA_WIDTH (IDATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (mac_clr),
    .en    (mac_en),
    .coeff (coeff),
    .sample(sample),
    .acc   (sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_phase <= 1'b0;
    end else if (load_out) begin
      out_data  <= sum[OUT_WIDTH-1:0];
      out_valid <= 1'b1;
      out_phase <= odd;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fir_interp2.sv
// Directed + random check of fir_interp2 against a polyphase convolution model.
module tb_fir_interp2;
  logic clk, rst_n;
  logic signed [11:0] in_data;
  logic in_valid, in_ready;
  logic signed [26:0] out_data;
  logic out_valid, out_ready, out_phase;

  int total = 0;
  int bad   = 0;
  int h [8] = '{41, 132, 341, 510, 510, 341, 132, 41};
  int hist [4] = '{0, 0, 0, 0};
  longint imp_exp [10] = '{41, 132, 341, 510, 510, 341, 132, 41, 0, 0};

  fir_interp2 dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_phase(out_phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint model(input bit ph);
    longint a = 0;
    for (int k = 0; k < 4; k++) a += longint'(h[2*k + int'(ph)]) * longint'(hist[k]);
    return a;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic signed [11:0] s);
    int n = 0;
    in_data  = s;
    in_valid = 1'b1;
    while (!in_ready && n < 40) begin step(); n++; end
    chk("in_ready_wait", longint'(in_ready), 1);
    step();
    in_valid = 1'b0;
    for (int k = 3; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = int'(s);
  endtask

  task automatic get(input bit ph, input int hold, output longint got);
    longint exp;
    int n = 0;
    exp = model(ph);
    out_ready = 1'b0;
    while (!out_valid && n < 40) begin step(); n++; end
    chk("latency", n, 4);
    for (int i = 0; i < hold; i++) begin
      chk("hold_data", longint'(out_data), exp);
      chk("hold_phase", longint'(out_phase), longint'(ph));
      chk("hold_in_ready", longint'(in_ready), 0);
      chk("hold_valid", longint'(out_valid), 1);
      step();
    end
    out_ready = 1'b1;
    got = longint'(out_data);
    chk(ph ? "odd_data" : "even_data", got, exp);
    chk("phase", longint'(out_phase), longint'(ph));
    step();
    out_ready = 1'b0;
    chk("valid_drop", longint'(out_valid), 0);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    chk({tag, "_valid"}, longint'(out_valid), 0);
    chk({tag, "_in_ready"}, longint'(in_ready), 1);
    chk({tag, "_data"}, longint'(out_data), 0);
    chk({tag, "_phase"}, longint'(out_phase), 0);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) hist[k] = 0;
    step();
  endtask

  task automatic impulse(input string tag);
    longint g;
    logic signed [11:0] s;
    for (int i = 0; i < 5; i++) begin
      s = (i == 0) ? 12'sd1 : 12'sd0;
      send(s);
      get(1'b0, 0, g); chk(tag, g, imp_exp[2*i]);
      get(1'b1, 0, g); chk(tag, g, imp_exp[2*i+1]);
    end
  endtask

  initial begin
    longint g;
    int n;
    logic signed [11:0] s;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    step(); step();
    chk("rst_valid", longint'(out_valid), 0);
    chk("rst_in_ready", longint'(in_ready), 1);
    chk("rst_data", longint'(out_data), 0);
    chk("rst_phase", longint'(out_phase), 0);
    rst_n = 1'b1;
    step();

    impulse("impulse");

    for (int i = 0; i < 6; i++) begin
      send(12'sd100);
      get(1'b0, 0, g); if (i >= 3) chk("dc_even", g, 102400);
      get(1'b1, 0, g); if (i >= 3) chk("dc_odd", g, 102400);
    end

    for (int i = 0; i < 6; i++) begin
      send(-12'sd2048);
      get(1'b0, 0, g); if (i >= 3) chk("negfs_even", g, -2097152);
      get(1'b1, 0, g); if (i >= 3) chk("negfs_odd", g, -2097152);
    end

    s = 12'($urandom);
    send(s);
    get(1'b0, 10, g);
    get(1'b1, 0, g);
    s = 12'($urandom);
    send(s);
    get(1'b0, 0, g);
    get(1'b1, 0, g);

    for (int i = 0; i < 16; i++) begin
      s = 12'($urandom);
      send(s);
      get(1'b0, $urandom_range(0, 3), g);
      get(1'b1, $urandom_range(0, 3), g);
    end

    s = 12'($urandom);
    send(s);
    n = 0;
    while (!out_valid && n < 40) begin step(); n++; end
    chk("oute_reached", longint'(out_valid), 1);
    step(); step();
    do_reset("rst_oute");
    impulse("post_rst_oute");

    for (int i = 0; i < 4; i++) begin
      s = 12'($urandom);
      send(s);
      get(1'b0, 0, g);
      get(1'b1, 0, g);
    end
    s = 12'($urandom);
    send(s);
    get(1'b0, 0, g);
    step();
    do_reset("rst_maco");
    impulse("post_rst_maco");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
